// File: rtl/conv_sched_if.sv
// conv_sched_if: signal bundle between the conv_sched controller and its
// surroundings (run/abort control, shared PE operand selects and control,
// captured results, status). The step input exists only when
// CONV_SCHED_STEP_EN is defined.
interface conv_sched_if #(
    parameter int ACC_W = 20
);
    logic             run;
    logic             abort;
`ifdef CONV_SCHED_STEP_EN
    logic             step;
`endif
    logic [3:0]       a_sel;
    logic [3:0]       b_sel;
    logic             pe_clr;
    logic             pe_en;
    logic [ACC_W-1:0] pe_acc;
    logic [1:0]       out_idx;
    logic             out_we;
    logic [ACC_W-1:0] res0;
    logic [ACC_W-1:0] res1;
    logic [ACC_W-1:0] res2;
    logic [ACC_W-1:0] res3;
    logic             busy;
    logic             done;

    // Controller side
    modport master (
`ifdef CONV_SCHED_STEP_EN
        input  step,
`endif
        input  run, abort, pe_acc,
        output a_sel, b_sel, pe_clr, pe_en, out_idx, out_we,
        output res0, res1, res2, res3, busy, done
    );

    // Environment side (operand registers, PE, run/display logic)
    modport slave (
`ifdef CONV_SCHED_STEP_EN
        output step,
`endif
        output run, abort, pe_acc,
        input  a_sel, b_sel, pe_clr, pe_en, out_idx, out_we,
        input  res0, res1, res2, res3, busy, done
    );
endinterface

// File: rtl/conv_sched.sv
// conv_sched: time-multiplexes one 8x8 MAC PE to compute the 2x2 valid
// convolution of a 4x4 image with a 3x3 kernel. For each of the four outputs
// it clears the PE, issues nine MACs, waits PE_LAT cycles for the pipeline to
// drain, then captures pe_acc into the matching result register.
// Build option: CONV_SCHED_STEP_EN adds a step input; MAC taps then advance
// only on cycles where step=1.
module conv_sched #(
    parameter int ACC_W  = 20,
    parameter int PE_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    conv_sched_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        CLR,
        MAC,
        DRAIN,
        STORE,
        DONE
    } state_t;

    // Last value of the drain counter; unused when PE_LAT is 0
    localparam logic [2:0] DRAIN_LAST = 3'((PE_LAT > 0) ? PE_LAT - 1 : 0);

    state_t     state_reg, state_next;
    logic [3:0] k_reg, k_next;
    logic [2:0] drain_reg, drain_next;
    logic [1:0] idx_reg, idx_next;

    logic       mac_adv;
    logic [3:0] a_base;
    logic [3:0] a_off;
    logic [3:0] a_sel_c;
    logic [3:0] b_sel_c;
    logic       pe_clr_c;
    logic       pe_en_c;
    logic       out_we_c;
    logic       done_c;

`ifdef CONV_SCHED_STEP_EN
    assign mac_adv = bus.step;
`else
    assign mac_adv = 1'b1;
`endif

    // Top-left image element of the current output window: 4*r + c
    assign a_base = {1'b0, idx_reg[1], 1'b0, idx_reg[0]};

    // Image offset of kernel tap k inside the window: 4*(k/3) + k%3
    always_comb begin
        case (k_reg)
            4'd0:    a_off = 4'd0;
            4'd1:    a_off = 4'd1;
            4'd2:    a_off = 4'd2;
            4'd3:    a_off = 4'd4;
            4'd4:    a_off = 4'd5;
            4'd5:    a_off = 4'd6;
            4'd6:    a_off = 4'd8;
            4'd7:    a_off = 4'd9;
            4'd8:    a_off = 4'd10;
            default: a_off = 4'd0;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            drain_reg <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            drain_reg <= drain_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state and output decode; abort overrides everything outside IDLE
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        drain_next = drain_reg;
        idx_next   = idx_reg;
        a_sel_c    = '0;
        b_sel_c    = '0;
        pe_clr_c   = 1'b0;
        pe_en_c    = 1'b0;
        out_we_c   = 1'b0;
        done_c     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (bus.run && !bus.abort) begin
                    state_next = CLR;
                end
            end
            CLR: begin
                pe_clr_c   = 1'b1;
                k_next     = '0;
                state_next = MAC;
            end
            MAC: begin
                pe_en_c = mac_adv;
                a_sel_c = a_base + a_off;
                b_sel_c = k_reg;
                if (mac_adv) begin
                    if (k_reg == 4'd8) begin
                        k_next     = '0;
                        drain_next = '0;
                        state_next = (PE_LAT > 0) ? DRAIN : STORE;
                    end else begin
                        k_next = k_reg + 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (drain_reg == DRAIN_LAST) begin
                    state_next = STORE;
                end else begin
                    drain_next = drain_reg + 3'd1;
                end
            end
            STORE: begin
                out_we_c = 1'b1;
                if (idx_reg == 2'd3) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + 2'd1;
                    state_next = CLR;
                end
            end
            DONE: begin
                done_c     = 1'b1;
                idx_next   = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (bus.abort && (state_reg != IDLE)) begin
            state_next = IDLE;
            k_next     = '0;
            drain_next = '0;
            idx_next   = '0;
            out_we_c   = 1'b0;
            done_c     = 1'b0;
        end
    end

    // One result register per output position, written on its store strobe
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_res
            logic [ACC_W-1:0] res_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    res_reg <= '0;
                end else if (out_we_c && (idx_reg == 2'(gi))) begin
                    res_reg <= bus.pe_acc;
                end
            end
        end
    endgenerate

    assign bus.a_sel   = a_sel_c;
    assign bus.b_sel   = b_sel_c;
    assign bus.pe_clr  = pe_clr_c;
    assign bus.pe_en   = pe_en_c;
    assign bus.out_idx = idx_reg;
    assign bus.out_we  = out_we_c;
    assign bus.done    = done_c;
    assign bus.busy    = (state_reg != IDLE);
    assign bus.res0    = g_res[0].res_reg;
    assign bus.res1    = g_res[1].res_reg;
    assign bus.res2    = g_res[2].res_reg;
    assign bus.res3    = g_res[3].res_reg;
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: drives two conv_sched instances (PE_LAT=1 and PE_LAT=3) with
// shared stimulus. Each has its own behavioural PE with the matching latency.
// Results are compared with a direct convolution model; cycle timing with the
// per-output period 11+PE_LAT.
module tb_conv_sched;
    localparam int ACC_W = 20;
    localparam int NCYC  = 160;

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic run_drv   = 1'b0;
    logic abort_drv = 1'b0;
`ifdef CONV_SCHED_STEP_EN
    logic step_drv  = 1'b1;
`endif
    logic [7:0] img [16];
    logic [7:0] ker [16];

    int total = 0;
    int bad   = 0;

    conv_sched_if #(.ACC_W(ACC_W)) bus1 ();
    conv_sched_if #(.ACC_W(ACC_W)) bus3 ();

    assign bus1.run   = run_drv;
    assign bus1.abort = abort_drv;
    assign bus3.run   = run_drv;
    assign bus3.abort = abort_drv;
`ifdef CONV_SCHED_STEP_EN
    assign bus1.step  = step_drv;
    assign bus3.step  = step_drv;
`endif

    always #5 clk = ~clk;

    conv_sched #(.ACC_W(ACC_W), .PE_LAT(1)) u_dut1 (.clk(clk), .reset(reset_n), .bus(bus1));
    conv_sched #(.ACC_W(ACC_W), .PE_LAT(3)) u_dut3 (.clk(clk), .reset(reset_n), .bus(bus3));

    // Behavioural PEs: product enters the accumulator PE_LAT cycles after issue
    logic [ACC_W-1:0] acc1 = '0;
    logic [ACC_W-1:0] acc3 = '0;
    logic [15:0]      pp1  = '0;
    logic             pv1  = 1'b0;
    logic [15:0]      pp3 [3] = '{default: '0};
    logic [2:0]       pv3  = '0;

    always @(posedge clk) begin
        if (bus1.pe_clr) begin
            acc1 <= '0;
            pv1  <= 1'b0;
        end else begin
            pv1 <= bus1.pe_en;
            pp1 <= img[bus1.a_sel] * ker[bus1.b_sel];
            if (pv1) acc1 <= acc1 + ACC_W'(pp1);
        end
    end

    always @(posedge clk) begin
        if (bus3.pe_clr) begin
            acc3 <= '0;
            pv3  <= '0;
        end else begin
            pv3    <= {pv3[1:0], bus3.pe_en};
            pp3[0] <= img[bus3.a_sel] * ker[bus3.b_sel];
            pp3[1] <= pp3[0];
            pp3[2] <= pp3[1];
            if (pv3[2]) acc3 <= acc3 + ACC_W'(pp3[2]);
        end
    end

    assign bus1.pe_acc = acc1;
    assign bus3.pe_acc = acc3;

    logic [ACC_W-1:0] r1 [4];
    logic [ACC_W-1:0] r3 [4];
    assign r1[0] = bus1.res0;
    assign r1[1] = bus1.res1;
    assign r1[2] = bus1.res2;
    assign r1[3] = bus1.res3;
    assign r3[0] = bus3.res0;
    assign r3[1] = bus3.res1;
    assign r3[2] = bus3.res2;
    assign r3[3] = bus3.res3;

    typedef struct packed {
        logic       busy;
        logic       pe_en;
        logic       pe_clr;
        logic       out_we;
        logic       done;
        logic [3:0] a_sel;
        logic [1:0] idx;
    } obs_t;
    obs_t h1 [NCYC];
    obs_t h3 [NCYC];

    typedef struct {
        int img_mode;
        int ker_mode;
        int exp_res [4];
    } vec_t;
    vec_t vecs [3];

    int exp1 [4];
    int exp3 [4];

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Direct 2x2 valid convolution of the current operand arrays
    function automatic int conv_ref(input int o);
        int r = o / 2;
        int c = o % 2;
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'(img[4 * (r + i) + c + j]) * int'(ker[3 * i + j]);
        return s;
    endfunction

    // Output n is stored at cycle (n+1)*(11+L); abort at cycle c blocks stores at cycles >= c
    task automatic model_job(input int abort_at);
        for (int n = 0; n < 4; n++) begin
            if (abort_at == 0 || (n + 1) * 12 < abort_at) exp1[n] = conv_ref(n);
            if (abort_at == 0 || (n + 1) * 14 < abort_at) exp3[n] = conv_ref(n);
        end
    endtask

    task automatic load(input int im, input int km);
        for (int i = 0; i < 16; i++) begin
            case (im)
                0:       img[i] = 8'd1;
                1:       img[i] = 8'(i);
                2:       img[i] = 8'd255;
                3:       img[i] = 8'd2;
                4:       img[i] = 8'd3;
                default: img[i] = 8'($urandom_range(0, 255));
            endcase
            if (i >= 9) ker[i] = 8'd0;
            else case (km)
                0:       ker[i] = 8'd1;
                1:       ker[i] = (i == 4) ? 8'd1 : 8'd0;
                2:       ker[i] = 8'd255;
                default: ker[i] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    // Cycle 0 is the run-sampling edge; h*[cyc] holds outputs seen during cycle cyc
    task automatic run_job(input int abort_at, input int hold_until, input int ncyc);
        for (int i = 0; i < NCYC; i++) begin
            h1[i] = '0;
            h3[i] = '0;
        end
        run_drv = 1'b1;
        tick();
        for (int cyc = 1; cyc < ncyc; cyc++) begin
            h1[cyc] = '{bus1.busy, bus1.pe_en, bus1.pe_clr, bus1.out_we, bus1.done, bus1.a_sel, bus1.out_idx};
            h3[cyc] = '{bus3.busy, bus3.pe_en, bus3.pe_clr, bus3.out_we, bus3.done, bus3.a_sel, bus3.out_idx};
            if (cyc >= hold_until) run_drv = 1'b0;
            if (cyc == abort_at) abort_drv = 1'b1;
            tick();
            abort_drv = 1'b0;
        end
        run_drv = 1'b0;
    endtask

    function automatic obs_t hist(input int which, input int cyc);
        return (which == 1) ? h1[cyc] : h3[cyc];
    endfunction

    task automatic check_res(input string tag);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("%s_lat1_res%0d", tag, n), r1[n], exp1[n]);
            chk($sformatf("%s_lat3_res%0d", tag, n), r3[n], exp3[n]);
        end
    endtask

    // Single-job timing: done at 4*(11+L)+1, stores at multiples of 11+L,
    // pe_en low for exactly L cycles before each store
    task automatic check_timing(input int which, input int ncyc);
        int lat = (which == 1) ? 1 : 3;
        int per = 11 + lat;
        int dq[$];
        int wq[$];
        for (int c = 1; c < ncyc; c++) begin
            if (hist(which, c).done) dq.push_back(c);
            if (hist(which, c).out_we) wq.push_back(c);
        end
        chk($sformatf("lat%0d_done_count", lat), dq.size(), 1);
        if (dq.size() > 0) chk($sformatf("lat%0d_done_cycle", lat), dq[0], 4 * per + 1);
        chk($sformatf("lat%0d_we_count", lat), wq.size(), 4);
        for (int n = 0; n < wq.size() && n < 4; n++) begin
            chk($sformatf("lat%0d_we_cycle%0d", lat, n), wq[n], (n + 1) * per);
            for (int d = 1; d <= lat; d++)
                chk($sformatf("lat%0d_drain_pe_en%0d", lat, n), hist(which, wq[n] - d).pe_en, 0);
            chk($sformatf("lat%0d_last_mac%0d", lat, n), hist(which, wq[n] - lat - 1).pe_en, 1);
        end
    endtask

    initial begin
        int aseq [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        int got[$];
        int d1[$];
        int d3[$];

        vecs[0].img_mode = 1; vecs[0].ker_mode = 1; vecs[0].exp_res = '{5, 6, 9, 10};
        vecs[1].img_mode = 2; vecs[1].ker_mode = 2; vecs[1].exp_res = '{585225, 585225, 585225, 585225};
        vecs[2].img_mode = 0; vecs[2].ker_mode = 0; vecs[2].exp_res = '{9, 9, 9, 9};
        for (int n = 0; n < 4; n++) begin
            exp1[n] = 0;
            exp3[n] = 0;
        end
        load(0, 0);

        // Reset state
        repeat (3) tick();
        chk("rst_busy1", bus1.busy, 0);
        chk("rst_busy3", bus3.busy, 0);
        chk("rst_pe_en", bus1.pe_en, 0);
        chk("rst_a_sel", bus1.a_sel, 0);
        chk("rst_done", bus1.done, 0);
        check_res("rst");
        reset_n = 1'b1;
        tick();
        chk("idle_busy", bus1.busy, 0);

        // Table-driven jobs
        for (int v = 0; v < 3; v++) begin
            load(vecs[v].img_mode, vecs[v].ker_mode);
            run_job(0, 1, 70);
            model_job(0);
            for (int n = 0; n < 4; n++) begin
                chk($sformatf("vec%0d_lat1_res%0d", v, n), r1[n], vecs[v].exp_res[n]);
                chk($sformatf("vec%0d_lat3_res%0d", v, n), r3[n], vecs[v].exp_res[n]);
            end
            check_timing(1, 70);
            check_timing(3, 70);
            if (vecs[v].img_mode == 1) begin
                got.delete();
                for (int c = 1; c < 70; c++)
                    if (h1[c].idx == 2'd3 && h1[c].pe_en) got.push_back(int'(h1[c].a_sel));
                chk("out3_a_sel_count", got.size(), 9);
                for (int i = 0; i < got.size() && i < 9; i++)
                    chk($sformatf("out3_a_sel%0d", i), got[i], aseq[i]);
            end
        end

        // Abort at cycle 20 after an all-ones job, new data a=2, b=1
        load(3, 0);
        run_job(20, 1, 70);
        model_job(20);
        check_res("abort20");
        chk("abort20_res0_const", r1[0], 18);
        chk("abort20_res1_const", r1[1], 9);
        chk("abort20_busy1", h1[21].busy, 0);
        chk("abort20_busy3", h3[21].busy, 0);
        for (int c = 1; c < 70; c++) begin
            if (h1[c].done || h3[c].done) chk($sformatf("abort20_no_done_c%0d", c), 1, 0);
        end

        // Abort coinciding with the first store: nothing is written
        load(4, 0);
        run_job(12, 1, 70);
        model_job(12);
        check_res("abort12");
        chk("abort12_res0_kept", r1[0], 18);

        // run held high: ignored while busy, restarts right after DONE
        load(0, 0);
        run_job(0, 60, 130);
        model_job(0);
        check_res("hold");
        d1.delete();
        d3.delete();
        for (int c = 1; c < 130; c++) begin
            if (h1[c].done) d1.push_back(c);
            if (h3[c].done) d3.push_back(c);
        end
        chk("hold_done_count1", d1.size(), 2);
        chk("hold_done_count3", d3.size(), 2);
        if (d1.size() == 2) begin
            chk("hold_done1_a", d1[0], 49);
            chk("hold_done1_b", d1[1], 99);
        end
        if (d3.size() == 2) begin
            chk("hold_done3_a", d3[0], 57);
            chk("hold_done3_b", d3[1], 115);
        end
        chk("hold_idle1", h1[50].busy, 0);
        chk("hold_restart1", h1[51].pe_clr, 1);
        chk("hold_idle3", h3[58].busy, 0);
        chk("hold_restart3", h3[59].pe_clr, 1);

        // Randomized jobs against the convolution model
        for (int t = 0; t < 6; t++) begin
            load(9, 9);
            run_job(0, 1, 70);
            model_job(0);
            check_res($sformatf("rand%0d", t));
        end

        // Reset asserted mid-MAC
        load(9, 9);
        run_drv = 1'b1;
        tick();
        run_drv = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        for (int n = 0; n < 4; n++) begin
            exp1[n] = 0;
            exp3[n] = 0;
        end
        chk("midrst_busy1", bus1.busy, 0);
        chk("midrst_busy3", bus3.busy, 0);
        chk("midrst_pe_en", bus1.pe_en, 0);
        chk("midrst_a_sel", bus1.a_sel, 0);
        chk("midrst_b_sel", bus1.b_sel, 0);
        check_res("midrst");
        tick();
        reset_n = 1'b1;
        tick();
        run_job(0, 1, 70);
        model_job(0);
        check_res("after_rst");
        check_timing(1, 70);

`ifdef CONV_SCHED_STEP_EN
        // Single-step: k stalls without step; nine pulses finish one output
        load(9, 9);
        step_drv = 1'b0;
        run_drv  = 1'b1;
        tick();
        run_drv = 1'b0;
        tick();
        repeat (4) tick();
        chk("step_stall_b_sel", bus1.b_sel, 0);
        chk("step_stall_busy", bus1.busy, 1);
        for (int p = 0; p < 9; p++) begin
            chk($sformatf("step_k%0d", p), bus1.b_sel, p);
            step_drv = 1'b1;
            tick();
            step_drv = 1'b0;
            tick();
        end
        chk("step_store", bus1.out_we, 1);
        tick();
        tick();
        chk("step_next_idx", bus1.out_idx, 1);
        chk("step_next_b_sel", bus1.b_sel, 0);
        chk("step_res0", r1[0], conv_ref(0));
        step_drv = 1'b1;
        repeat (100) tick();
        model_job(0);
        check_res("step");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
